// File: rtl/truth_table_sweeper.sv
// Stimulus and checking stage for the block z = x1 | (x2 & x3).
// Steps through all eight input patterns, holds each HOLD cycles and checks z at the end of each window.
module truth_table_sweeper #(
  parameter int HOLD = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       z,
  output logic       x1,
  output logic       x2,
  output logic       x3,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] first_fail
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] LAST = 8'(HOLD - 1);

  state_t     r_state;
  logic [2:0] r_pat;
  logic [7:0] r_cnt;
  logic [3:0] r_errCount;
  logic [2:0] r_firstFail;
  logic [2:0] r_x;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;

  logic       w_exp;
  logic       w_miss;
  logic [3:0] w_errNext;

  assign w_exp     = r_pat[2] | (r_pat[1] & r_pat[0]);
  assign w_miss    = z ^ w_exp;
  assign w_errNext = r_errCount + {3'd0, w_miss};

  // DONE behaves like IDLE on start, so a held-high start reruns back to back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pat       <= 3'd0;
      r_cnt       <= 8'd0;
      r_errCount  <= 4'd0;
      r_firstFail <= 3'd0;
      r_x         <= 3'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state     <= RUN;
            r_pat       <= 3'd0;
            r_cnt       <= 8'd0;
            r_errCount  <= 4'd0;
            r_firstFail <= 3'd0;
            r_x         <= 3'd0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
          end
        end
        RUN: begin
          if (r_cnt != LAST) begin
            r_cnt <= r_cnt + 8'd1;
          end else begin
            r_cnt      <= 8'd0;
            r_errCount <= w_errNext;
            if (w_miss && (r_errCount == 4'd0)) begin
              r_firstFail <= r_pat;
            end
            if (r_pat != 3'd7) begin
              r_pat <= r_pat + 3'd1;
              r_x   <= r_pat + 3'd1;
            end else begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_errNext == 4'd0);
              r_x     <= 3'd0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign x1         = r_x[2];
  assign x2         = r_x[1];
  assign x3         = r_x[0];
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_count  = r_errCount;
  assign first_fail = r_firstFail;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: HOLD=10 and HOLD=2 instances driven by a programmable z truth table.
// Expected results come from a pattern-by-pattern reference of x1 | (x2 & x3).
module tb_truth_table_sweeper;

  typedef struct {
    string      name;
    logic       useHold2;
    logic [7:0] zTab;
    int         expErr;
    int         expFirst;
    logic       expPass;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       sel;
  logic [7:0] zTab;

  logic       startA, startB, zA, zB;
  logic       x1A, x2A, x3A, busyA, doneA, passA;
  logic       x1B, x2B, x3B, busyB, doneB, passB;
  logic [3:0] errA, errB;
  logic [2:0] firstA, firstB;

  logic [2:0] oX;
  logic       oBusy, oDone, oPass;
  logic [3:0] oErr;
  logic [2:0] oFirst;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign startA = start & ~sel;
  assign startB = start & sel;

  // The downstream block's behaviour is whatever zTab says for the pattern it sees.
  always_comb begin
    zA = zTab[{x1A, x2A, x3A}];
    zB = zTab[{x1B, x2B, x3B}];
  end

  always_comb begin
    if (sel) begin
      oX = {x1B, x2B, x3B}; oBusy = busyB; oDone = doneB; oPass = passB; oErr = errB; oFirst = firstB;
    end else begin
      oX = {x1A, x2A, x3A}; oBusy = busyA; oDone = doneA; oPass = passA; oErr = errA; oFirst = firstA;
    end
  end

  truth_table_sweeper #(.HOLD(10)) dutA (
    .clk(clk), .rst(rst), .start(startA), .z(zA),
    .x1(x1A), .x2(x2A), .x3(x3A), .busy(busyA), .done(doneA), .pass(passA),
    .err_count(errA), .first_fail(firstA)
  );

  truth_table_sweeper #(.HOLD(2)) dutB (
    .clk(clk), .rst(rst), .start(startB), .z(zB),
    .x1(x1B), .x2(x2B), .x3(x3B), .busy(busyB), .done(doneB), .pass(passB),
    .err_count(errB), .first_fail(firstB)
  );

  function automatic logic refFn(int p);
    return (p >= 4) || (p == 3);
  endfunction

  function automatic logic [7:0] goodTable();
    logic [7:0] t;
    for (int p = 0; p < 8; p++) t[p] = refFn(p);
    return t;
  endfunction

  function automatic logic [12:0] packAll();
    return {oBusy, oDone, oPass, oX, oErr, oFirst};
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Chooses the instance and z table, then pulses start so it is accepted at the next edge (E0).
  task automatic applyStimulus(input logic useHold2, input logic [7:0] tab);
    @(posedge clk);
    #1;
    sel   = useHold2;
    zTab  = tab;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic runSweep(input string name, input int hold, input int expErr, input int expFirst,
                          input logic expPass, input bit repulse);
    checkOutput({name, ".startClear"}, packAll(), {1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 3'd0});
    for (int k = 1; k <= 8 * hold; k++) begin
      @(posedge clk);
      #1;
      if (k < 8 * hold) begin
        checkOutput({name, ".trace"}, {oBusy, oDone, oX}, {1'b1, 1'b0, 3'(k / hold)});
      end else begin
        checkOutput({name, ".final"}, packAll(),
                    {1'b0, 1'b1, expPass, 3'd0, 4'(expErr), 3'(expFirst)});
      end
      if (repulse) start = (k == 5) || (k == 40);
    end
  endtask

  vec_t vecs[5];

  initial begin
    logic [7:0] t;
    int         mErr, mFirst;

    vecs[0] = '{"correct",   1'b0, 8'hF8, 0, 0, 1'b1};
    vecs[1] = '{"stuck0",    1'b0, 8'h00, 5, 3, 1'b0};
    vecs[2] = '{"stuck1",    1'b0, 8'hFF, 3, 0, 1'b0};
    vecs[3] = '{"inverted",  1'b1, 8'h07, 8, 0, 1'b0};
    vecs[4] = '{"lastOnly",  1'b1, 8'h78, 1, 7, 1'b0};

    rst   = 1'b1;
    start = 1'b0;
    sel   = 1'b0;
    zTab  = 8'hF8;
    #1;
    checkOutput("resetState", packAll(), 13'd0);

    // Start raised in the same cycle reset releases must be taken on the next edge.
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("startAtRelease", {oBusy, oDone, oX}, {1'b1, 1'b0, 3'd0});
    for (int k = 1; k <= 44; k++) begin
      @(posedge clk);
      #1;
      checkOutput("preResetTrace", {oBusy, oDone, oX}, {1'b1, 1'b0, 3'(k / 10)});
    end
    #3;
    rst = 1'b1;
    #1;
    checkOutput("asyncReset", packAll(), 13'd0);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      checkOutput("noDoneAfterReset", {oBusy, oDone, oPass, oX}, 6'd0);
    end

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].useHold2, vecs[i].zTab);
      runSweep(vecs[i].name, vecs[i].useHold2 ? 2 : 10, vecs[i].expErr, vecs[i].expFirst,
               vecs[i].expPass, 1'b0);
    end

    // Start pulses during a running sweep are ignored; then a fresh start in DONE reruns.
    applyStimulus(1'b0, 8'h00);
    runSweep("repulse", 10, 5, 3, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("doneHeld", packAll(), {1'b0, 1'b1, 1'b0, 3'd0, 4'd5, 3'd3});
    applyStimulus(1'b0, goodTable());
    runSweep("rerun", 10, 0, 0, 1'b1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      t = 8'($urandom);
      mErr = 0;
      mFirst = 0;
      for (int p = 0; p < 8; p++) begin
        if (t[p] != refFn(p)) begin
          if (mErr == 0) mFirst = p;
          mErr++;
        end
      end
      applyStimulus(1'($urandom), t);
      runSweep("random", sel ? 2 : 10, mErr, mFirst, mErr == 0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
